// File: rtl/store_buffer.sv
// Circular store buffer: allocate at dispatch, write back from the LSU, commit from
// the ROB, drain committed stores to memory in order, and forward to younger loads.
module store_buffer #(
  parameter int SB_ENTRY    = 8,
  parameter int WORD_SIZE_P = 16,
  localparam int IW = $clog2(SB_ENTRY)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   alloc_v_i,
  output logic                   alloc_ready_o,
  output logic [IW-1:0]          alloc_idx_o,
  input  logic                   wb_v_i,
  input  logic [IW-1:0]          wb_sb_dest_i,
  input  logic [WORD_SIZE_P-1:0] wb_addr_i,
  input  logic [WORD_SIZE_P-1:0] wb_data_i,
  input  logic                   commit_v_i,
  input  logic [WORD_SIZE_P-1:0] ld_addr_i,
  input  logic [IW-1:0]          ld_sb_num_i,
  output logic                   ld_bypass_valid_o,
  output logic [WORD_SIZE_P-1:0] ld_bypass_value_o,
  output logic                   mem_w_v_o,
  output logic [WORD_SIZE_P-1:0] mem_w_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_w_data_o,
  input  logic                   mem_w_ready_i,
  input  logic                   mispredict_i,
  output logic [IW:0]            count_o
);

  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [IW:0]   count_q, count_d;
  logic [SB_ENTRY-1:0] busy_q, busy_d, written_q, written_d, committed_q, committed_d;
  logic [SB_ENTRY-1:0][WORD_SIZE_P-1:0] addr_q, data_q;

  logic alloc_fire, wb_fire, drain_fire, found;
  logic [IW:0]   ccnt;
  logic [IW-1:0] idx, rng;

  assign alloc_ready_o = (count_q < (IW+1)'(SB_ENTRY));
  assign alloc_idx_o   = tail_q;
  assign count_o       = count_q;
  assign alloc_fire    = alloc_v_i && alloc_ready_o && !mispredict_i;
  assign wb_fire       = wb_v_i && busy_q[wb_sb_dest_i] && !mispredict_i;

  assign mem_w_v_o    = busy_q[head_q] && written_q[head_q] && committed_q[head_q];
  assign mem_w_addr_o = addr_q[head_q];
  assign mem_w_data_o = data_q[head_q];
  assign drain_fire   = mem_w_v_o && mem_w_ready_i;

  always_comb begin
    busy_d      = busy_q;
    written_d   = written_q;
    committed_d = committed_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    found       = 1'b0;
    ccnt        = '0;
    idx         = '0;
    // Busy entries are contiguous from head, so the first uncommitted one is the oldest.
    if (commit_v_i) begin
      for (int k = 0; k < SB_ENTRY; k++) begin
        idx = head_q + IW'(k);
        if (!found && busy_q[idx] && !committed_q[idx]) begin
          committed_d[idx] = 1'b1;
          found            = 1'b1;
        end
      end
    end
    if (wb_fire) written_d[wb_sb_dest_i] = 1'b1;
    for (int i = 0; i < SB_ENTRY; i++)
      ccnt = ccnt + (IW+1)'(busy_q[i] & committed_d[i]);
    if (drain_fire) begin
      busy_d[head_q]      = 1'b0;
      written_d[head_q]   = 1'b0;
      committed_d[head_q] = 1'b0;
      head_d              = head_q + 1'b1;
    end
    if (mispredict_i) begin
      busy_d  = busy_d & committed_d;
      tail_d  = head_q + ccnt[IW-1:0];
      count_d = ccnt - (IW+1)'(drain_fire);
    end else begin
      if (alloc_fire) begin
        busy_d[tail_q]      = 1'b1;
        written_d[tail_q]   = 1'b0;
        committed_d[tail_q] = 1'b0;
        tail_d              = tail_q + 1'b1;
      end
      count_d = count_q + (IW+1)'(alloc_fire) - (IW+1)'(drain_fire);
    end
  end

  // Forwarding window is [head, ld_sb_num); later hits override, leaving the youngest.
  always_comb begin
    ld_bypass_valid_o = 1'b0;
    ld_bypass_value_o = '0;
    rng               = ld_sb_num_i - head_q;
    for (int k = 0; k < SB_ENTRY; k++) begin
      if (IW'(k) < rng && busy_q[head_q + IW'(k)] && written_q[head_q + IW'(k)] &&
          addr_q[head_q + IW'(k)] == ld_addr_i) begin
        ld_bypass_valid_o = 1'b1;
        ld_bypass_value_o = data_q[head_q + IW'(k)];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      written_q   <= '0;
      committed_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      written_q   <= written_d;
      committed_q <= committed_d;
    end
  end

  // Payload is qualified by the written bit, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (wb_fire) begin
      addr_q[wb_sb_dest_i] <= wb_addr_i;
      data_q[wb_sb_dest_i] <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: memory writes go through a scoreboard queue,
// forwarding/occupancy are checked against hand-computed values.
module tb_store_buffer;
  localparam int N = 8;
  localparam int W = 16;

  logic clk, reset_n;
  logic alloc_v, alloc_ready;
  logic [2:0] alloc_idx;
  logic wb_v;
  logic [2:0] wb_dest;
  logic [W-1:0] wb_addr, wb_data;
  logic commit_v;
  logic [W-1:0] ld_addr;
  logic [2:0] ld_sb_num;
  logic ld_bv;
  logic [W-1:0] ld_val;
  logic mem_v;
  logic [W-1:0] mem_addr, mem_data;
  logic mem_ready, mispredict;
  logic [3:0] count;

  typedef struct { logic [W-1:0] a; logic [W-1:0] d; } wr_t;
  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;

  store_buffer #(.SB_ENTRY(N), .WORD_SIZE_P(W)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .alloc_v_i(alloc_v), .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
    .wb_v_i(wb_v), .wb_sb_dest_i(wb_dest), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .commit_v_i(commit_v), .ld_addr_i(ld_addr), .ld_sb_num_i(ld_sb_num),
    .ld_bypass_valid_o(ld_bv), .ld_bypass_value_o(ld_val),
    .mem_w_v_o(mem_v), .mem_w_addr_o(mem_addr), .mem_w_data_o(mem_data),
    .mem_w_ready_i(mem_ready), .mispredict_i(mispredict), .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every accepted memory write must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && mem_v && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_unexpected got=%0h/%0h exp=none", mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("mem_addr", {16'h0, mem_addr}, {16'h0, e.a});
        chk("mem_data", {16'h0, mem_data}, {16'h0, e.d});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    alloc_v = 0; wb_v = 0; commit_v = 0; mispredict = 0;
    #1;
  endtask

  task automatic wb(input logic [2:0] d, input logic [W-1:0] a, input logic [W-1:0] v);
    wb_v = 1; wb_dest = d; wb_addr = a; wb_data = v;
    cyc();
  endtask

  task automatic ld(input string nm, input logic [W-1:0] a, input logic [2:0] n,
                    input logic ev, input logic [W-1:0] eval);
    ld_addr = a; ld_sb_num = n;
    #1;
    chk({nm, "_v"}, {31'h0, ld_bv}, {31'h0, ev});
    chk({nm, "_val"}, {16'h0, ld_val}, {16'h0, eval});
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n = 0; alloc_v = 0; wb_v = 0; wb_dest = 0; wb_addr = 0; wb_data = 0;
    commit_v = 0; ld_addr = 0; ld_sb_num = 0; mem_ready = 0; mispredict = 0;
    #2;
    chk("rst_ready", {31'h0, alloc_ready}, 1);
    chk("rst_idx", {29'h0, alloc_idx}, 0);
    chk("rst_memv", {31'h0, mem_v}, 0);
    chk("rst_bv", {31'h0, ld_bv}, 0);
    chk("rst_bval", {16'h0, ld_val}, 0);
    chk("rst_count", {28'h0, count}, 0);
    @(negedge clk); reset_n = 1;
    cyc();

    // three allocations, forward from idx1
    for (int i = 0; i < 3; i++) begin
      chk("alloc_idx", {29'h0, alloc_idx}, i);
      alloc_v = 1; cyc();
    end
    chk("count3", {28'h0, count}, 3);
    wb(3'd1, 16'h0040, 16'hBEEF);
    ld("byp_beef", 16'h0040, 3'd3, 1, 16'hBEEF);
    ld("byp_excl", 16'h0040, 3'd1, 0, 16'h0);

    // youngest older match wins
    wb(3'd0, 16'h0010, 16'h1111);
    wb(3'd2, 16'h0010, 16'h2222);
    ld("byp_young", 16'h0010, 3'd3, 1, 16'h2222);
    ld("byp_older", 16'h0010, 3'd2, 1, 16'h1111);
    ld("byp_empty", 16'h0010, 3'd0, 0, 16'h0);

    // commit idx0, stall memory for 3 cycles
    push(16'h0010, 16'h1111);
    commit_v = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      chk("stall_memv", {31'h0, mem_v}, 1);
      chk("stall_count", {28'h0, count}, 3);
      cyc();
    end
    mem_ready = 1; cyc();
    mem_ready = 0;
    chk("drain_count", {28'h0, count}, 2);
    chk("drain_memv", {31'h0, mem_v}, 0);

    // commit/drain idx1 and idx2 back to back
    push(16'h0040, 16'hBEEF);
    push(16'h0010, 16'h2222);
    mem_ready = 1;
    commit_v = 1; cyc();
    commit_v = 1; cyc();
    cyc();
    mem_ready = 0;
    chk("empty_count", {28'h0, count}, 0);

    // fill (head=3), then alloc + drain in the same cycle
    for (int i = 0; i < N; i++) begin alloc_v = 1; cyc(); end
    chk("full_count", {28'h0, count}, 8);
    chk("full_ready", {31'h0, alloc_ready}, 0);
    chk("full_idx", {29'h0, alloc_idx}, 3);
    wb(3'd3, 16'h0100, 16'hA003);
    commit_v = 1; cyc();
    chk("full_memv", {31'h0, mem_v}, 1);
    push(16'h0100, 16'hA003);
    mem_ready = 1; alloc_v = 1; cyc();
    mem_ready = 0;
    chk("ad_count", {28'h0, count}, 7);
    chk("ad_idx", {29'h0, alloc_idx}, 3);
    chk("ad_ready", {31'h0, alloc_ready}, 1);

    // flush all uncommitted (head=4), alloc in the flush cycle is dropped
    mispredict = 1; alloc_v = 1; cyc();
    chk("flush0_count", {28'h0, count}, 0);
    chk("flush0_idx", {29'h0, alloc_idx}, 4);

    // 5 allocated, 2 committed, mispredict
    for (int i = 0; i < 5; i++) begin alloc_v = 1; cyc(); end
    commit_v = 1; cyc();
    commit_v = 1; cyc();
    chk("pre_flush_count", {28'h0, count}, 5);
    mispredict = 1; alloc_v = 1; cyc();
    chk("flush2_count", {28'h0, count}, 2);
    chk("flush2_idx", {29'h0, alloc_idx}, 6);
    alloc_v = 1; cyc();
    chk("post_flush_count", {28'h0, count}, 3);

    // drain idx4, idx5 -> head=6
    push(16'h0200, 16'h4444);
    push(16'h0201, 16'h5555);
    mem_ready = 1;
    wb(3'd4, 16'h0200, 16'h4444);
    wb(3'd5, 16'h0201, 16'h5555);
    cyc();
    mem_ready = 0;
    chk("h6_count", {28'h0, count}, 1);
    chk("h6_idx", {29'h0, alloc_idx}, 7);
    alloc_v = 1; cyc();
    alloc_v = 1; cyc();
    chk("wrap_count", {28'h0, count}, 3);
    chk("wrap_idx", {29'h0, alloc_idx}, 1);
    wb(3'd0, 16'h0300, 16'hC0C0);
    wb(3'd6, 16'h0300, 16'h6666);
    ld("wrap_idx0", 16'h0300, 3'd1, 1, 16'hC0C0);
    ld("wrap_idx6", 16'h0300, 3'd0, 1, 16'h6666);
    ld("wrap_none", 16'h0300, 3'd6, 0, 16'h0);

    // commit idx6 with memory stalled, then reset mid-stream
    commit_v = 1; cyc();
    chk("pre_rst_memv", {31'h0, mem_v}, 1);
    reset_n = 0;
    #1;
    chk("mrst_ready", {31'h0, alloc_ready}, 1);
    chk("mrst_idx", {29'h0, alloc_idx}, 0);
    chk("mrst_memv", {31'h0, mem_v}, 0);
    chk("mrst_bv", {31'h0, ld_bv}, 0);
    chk("mrst_bval", {16'h0, ld_val}, 0);
    chk("mrst_count", {28'h0, count}, 0);
    @(negedge clk); reset_n = 1;
    mem_ready = 1;
    cyc(); cyc();
    chk("post_rst_memv", {31'h0, mem_v}, 0);
    chk("post_rst_count", {28'h0, count}, 0);
    mem_ready = 0;
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_ENTRY, default 8, number of entries (power of two, >=2).
REQ-002 SHALL have parameter WORD_SIZE_P, default 16, address/data width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port alloc_v_i  input  1  dispatch requests one store entry.
REQ-006 SHALL have port alloc_ready_o  output  1  entry available (count < SB_ENTRY).
REQ-007 SHALL have port alloc_idx_o  output  $clog2(SB_ENTRY)  tail index; the store's sb_dest, and the load's bypass boundary.
REQ-008 SHALL have port wb_v_i  input  1  LSU store writeback valid.
REQ-009 SHALL have ports wb_sb_dest_i  input  $clog2(SB_ENTRY), wb_addr_i  input  WORD_SIZE_P, wb_data_i  input  WORD_SIZE_P  entry index, address, data.
REQ-010 SHALL have port commit_v_i  input  1  ROB retires the oldest uncommitted store.
REQ-011 SHALL have ports ld_addr_i  input  WORD_SIZE_P, ld_sb_num_i  input  $clog2(SB_ENTRY)  load address and the tail index captured at load dispatch.
REQ-012 SHALL have ports ld_bypass_valid_o  output  1, ld_bypass_value_o  output  WORD_SIZE_P  forwarding result.
REQ-013 SHALL have ports mem_w_v_o  output  1, mem_w_addr_o  output  WORD_SIZE_P, mem_w_data_o  output  WORD_SIZE_P, mem_w_ready_i  input  1  memory write handshake.
REQ-014 SHALL have port mispredict_i  input  1  flush all uncommitted entries.
REQ-015 SHALL have port count_o  output  $clog2(SB_ENTRY)+1  occupied entries.

Function
REQ-016 SHALL be a circular FIFO with head (oldest) and tail pointers; pointers wrap from SB_ENTRY-1 to 0.
REQ-017 SHALL track per entry: busy, written (addr/data valid), committed, addr, data.
REQ-018 SHALL, on alloc_v_i && alloc_ready_o && !mispredict_i, set entry[tail] busy=1, written=0, committed=0, and advance tail next cycle.
REQ-019 SHALL ignore alloc_v_i when alloc_ready_o=0; alloc_ready_o depends only on the current count, not on a same-cycle drain.
REQ-020 SHALL, on wb_v_i to a busy entry, set written=1 and latch addr/data; SHALL ignore wb_v_i to a non-busy entry.
REQ-021 SHALL, on commit_v_i, set committed=1 on the oldest busy uncommitted entry; SHALL ignore commit_v_i when no such entry exists.
REQ-022 SHALL drive mem_w_v_o=1 combinationally when entry[head] is busy, written, and committed, with mem_w_addr_o/mem_w_data_o taken from entry[head].
REQ-023 SHALL, on mem_w_v_o && mem_w_ready_i, clear entry[head] busy and advance head next cycle; at most one drain per cycle.
REQ-024 SHALL compute the bypass combinationally over entries from head up to, but excluding, ld_sb_num_i (wrap-aware), considering only busy, written entries with addr == ld_addr_i.
REQ-025 SHALL select the youngest matching entry and drive its data on ld_bypass_value_o with ld_bypass_valid_o=1; with no match, ld_bypass_valid_o=0 and ld_bypass_value_o=0.
REQ-026 SHALL, when ld_sb_num_i == head, consider no entries for bypass (empty older range).
REQ-027 SHALL, on mispredict_i, clear busy on every uncommitted entry and set tail to head + committed-entry count (mod SB_ENTRY) next cycle; alloc and wb in that cycle are ignored; commit and drain in that cycle proceed.
REQ-028 SHALL update count_o each cycle as old + alloc - drain, or committed count (minus drain) after mispredict.
REQ-029 SHALL allow alloc, wb, commit, and drain in the same cycle, including wb and commit to the same entry.

Reset
REQ-030 SHALL, on reset_n_i low, asynchronously clear head, tail, all busy/written/committed bits, and count_o.
REQ-031 SHALL, in reset, drive alloc_ready_o=1, alloc_idx_o=0, mem_w_v_o=0, ld_bypass_valid_o=0, ld_bypass_value_o=0, count_o=0.
REQ-032 SHALL discard all in-flight entries on reset mid-operation; no mem write follows deassertion until a new commit.

Verification
REQ-033 SHALL cover: 3 allocs -> idx 0,1,2; wb idx1 addr=0x0040 data=0xBEEF; load addr 0x0040, sb_num=3 -> bypass valid, value 0xBEEF.
REQ-034 SHALL cover: idx0 and idx2 both written addr 0x0010 (data 0x1111, 0x2222); load sb_num=3 -> 0x2222; load sb_num=2 -> 0x1111.
REQ-035 SHALL cover: fill 8 entries -> alloc_ready_o=0, count_o=8; alloc plus drain in the same cycle -> alloc ignored, count_o=7.
REQ-036 SHALL cover: commit idx0 (written), hold mem_w_ready_i=0 for 3 cycles -> mem_w_v_o stays 1, head stays 0; ready=1 -> head=1 next cycle.
REQ-037 SHALL cover: 5 allocated, 2 committed, mispredict -> count_o=2, tail=head+2; next alloc returns head+2.
REQ-038 SHALL cover: head=6 with wrap, entries 6,7,0 busy, load sb_num=1 matching idx0 -> bypass from idx0; reset pulse mid-stream -> all outputs at reset values.
